mux_arbiter: RTL and testbench

Round-robin arbiter that shares one N:1 multiplexer datapath among N requesters. Each requester raises a request, receives a one-hot grant, and holds it until it drops its request or exceeds a hold limit while others wait. The block owns the mux select, so downstream logic sees a single output stream with a valid flag and the owner's index.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux_arbiter_rr_pick.sv | 37 +++
 rtl/mux_arbiter.sv | 128 ++++++++++++
 tb/tb_mux_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The one-hot helper is sized for the largest supported requester count.
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int MAX_N = 8;
    localparam int IDX_W = 3;
    localparam int DEF_N = 4;
    localparam int SEL_W = $clog2(DEF_N);

    function automatic logic [MAX_N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin search: the first requester at or after start,
// wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic          found,
    output logic [SW-1:0] winner
);

    logic [N-1:0]  hit;
    logic [SW-1:0] cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [SW:0] sum;
            assign sum       = {1'b0, start} + (SW+1)'(gi);
            assign cand[gi]  = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : sum[SW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning an N:1 data mux, with a per-owner hold limit
// that forces rotation only while other requesters are waiting.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic                 out_valid,
    output logic [W-1:0]         out_data
);

    localparam int SW = $clog2(N);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_t    state_reg, state_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [SW-1:0] sel_reg, sel_next;
    logic [SW-1:0] last_reg, last_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [SW-1:0] start;
    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic          owner_req;
    logic          others_req;
    logic [W-1:0]  lane [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign lane[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // While owning, last equals sel, so one search start serves both states.
    assign start      = (last_reg == SW'(N - 1)) ? '0 : last_reg + SW'(1);
    assign owner_req  = req[sel_reg];
    assign others_req = |(req & ~gnt_reg);
    assign pick_oh    = N'(onehot(IDX_W'(pick_idx)));

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .start  (start),
        .found  (pick_found),
        .winner (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            last_reg  <= SW'(N - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = OWN;
                    gnt_next   = pick_oh;
                    sel_next   = pick_idx;
                    last_next  = pick_idx;
                    cnt_next   = '0;
                end
            end
            OWN: begin
                if (owner_req) begin
                    if (cnt_reg < HOLD_LAST) begin
                        cnt_next = cnt_reg + CW'(1);
                    end else if (others_req && pick_found) begin
                        gnt_next  = pick_oh;
                        sel_next  = pick_idx;
                        last_next = pick_idx;
                        cnt_next  = '0;
                    end
                end else if (pick_found) begin
                    gnt_next  = pick_oh;
                    sel_next  = pick_idx;
                    last_next = pick_idx;
                    cnt_next  = '0;
                end else begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = |gnt_reg;
        out_data  = '0;
        if (|gnt_reg) begin
            out_data = lane[sel_reg];
        end
    end

    assign gnt = gnt_reg;
    assign sel = sel_reg;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (N=4, W=1, MAX_HOLD=8); inputs are driven
// and outputs sampled on the falling clock edge.
module tb_mux_arbiter;
    import mux_arb_pkg::*;

    localparam int N        = 4;
    localparam int W        = 1;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic [W-1:0]     out_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic do_reset;
        req     = '0;
        in_data = '0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        req     = 4'b1111;
        in_data = 4'b1111;
        repeat (2) @(negedge clk);
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 1'b0); end
        tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got=%0d exp=%0d", sel, 0); end
        tests++; if (out_data !== 1'b0) begin fails++; $display("FAIL reset_data got=%b exp=%b", out_data, 1'b0); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL reset_release_gnt got=%b exp=%b", gnt, 4'b0001); end
        tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_release_sel got=%0d exp=%0d", sel, 0); end
        tests++; if (out_data !== 1'b1) begin fails++; $display("FAIL reset_release_data got=%b exp=%b", out_data, 1'b1); end
        $display("[TB] test_reset: checks so far %0d", tests);
    endtask

    task automatic test_single_owner;
        do_reset();
        req     = 4'b0100;
        in_data = 4'b0100;
        @(negedge clk);
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_first_gnt got=%b exp=%b", gnt, 4'b0100); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_hold_gnt cyc=%0d got=%b exp=%b", i, gnt, 4'b0100); end
            tests++; if (out_data !== 1'b1) begin fails++; $display("FAIL single_hold_data cyc=%0d got=%b exp=%b", i, out_data, 1'b1); end
        end
        in_data = 4'b1011;
        #1;
        tests++; if (out_data !== 1'b0) begin fails++; $display("FAIL single_comb_data got=%b exp=%b", out_data, 1'b0); end
        @(negedge clk);
        req     = 4'b0000;
        in_data = 4'b0100;
        @(negedge clk);
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_drop_gnt got=%b exp=%b", gnt, 4'b0000); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drop_valid got=%b exp=%b", out_valid, 1'b0); end
        tests++; if (out_data !== 1'b0) begin fails++; $display("FAIL single_drop_data got=%b exp=%b", out_data, 1'b0); end
        $display("[TB] test_single_owner: checks so far %0d", tests);
    endtask

    task automatic test_saturate;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        repeat (12) @(negedge clk);
        req = 4'b0101;
        @(negedge clk);
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL saturate_rotate_gnt got=%b exp=%b", gnt, 4'b0001); end
        tests++; if (sel !== 2'd0) begin fails++; $display("FAIL saturate_rotate_sel got=%0d exp=%0d", sel, 0); end
        $display("[TB] test_saturate: checks so far %0d", tests);
    endtask

    task automatic test_fair_rotation;
        logic [MAX_N-1:0] oh;
        logic [N-1:0]     exp_gnt;
        logic [N*W-1:0]   pattern;
        do_reset();
        pattern = 4'b1010;
        req     = 4'b1111;
        in_data = pattern;
        for (int g = 0; g < 8; g++) begin
            oh      = onehot(3'(g % 4));
            exp_gnt = oh[N-1:0];
            for (int c = 0; c < MAX_HOLD; c++) begin
                @(negedge clk);
                tests++; if (gnt !== exp_gnt) begin fails++; $display("FAIL rotation_gnt turn=%0d cyc=%0d got=%b exp=%b", g, c, gnt, exp_gnt); end
                tests++; if (sel !== 2'(g % 4)) begin fails++; $display("FAIL rotation_sel turn=%0d cyc=%0d got=%0d exp=%0d", g, c, sel, g % 4); end
                tests++; if (out_data !== pattern[g % 4]) begin fails++; $display("FAIL rotation_data turn=%0d cyc=%0d got=%b exp=%b", g, c, out_data, pattern[g % 4]); end
            end
        end
        $display("[TB] test_fair_rotation: checks so far %0d", tests);
    endtask

    task automatic test_back_to_back;
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL b2b_first_gnt got=%b exp=%b", gnt, 4'b0010); end
        req = 4'b0110;
        @(negedge clk);
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL b2b_hold_gnt got=%b exp=%b", gnt, 4'b0010); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_hold_valid got=%b exp=%b", out_valid, 1'b1); end
        req = 4'b0100;
        @(negedge clk);
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL b2b_handover_gnt got=%b exp=%b", gnt, 4'b0100); end
        tests++; if (sel !== 2'd2) begin fails++; $display("FAIL b2b_handover_sel got=%0d exp=%0d", sel, 2); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_handover_valid got=%b exp=%b", out_valid, 1'b1); end
        $display("[TB] test_back_to_back: checks so far %0d", tests);
    endtask

    task automatic test_wrap;
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_owner_gnt got=%b exp=%b", gnt, 4'b1000); end
        tests++; if (sel !== 2'd3) begin fails++; $display("FAIL wrap_owner_sel got=%0d exp=%0d", sel, 3); end
        req = 4'b0011;
        @(negedge clk);
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL wrap_gnt got=%b exp=%b", gnt, 4'b0001); end
        tests++; if (sel !== 2'd0) begin fails++; $display("FAIL wrap_sel got=%0d exp=%0d", sel, 0); end
        $display("[TB] test_wrap: checks so far %0d", tests);
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midrst_owner_gnt got=%b exp=%b", gnt, 4'b0100); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL midrst_gnt got=%b exp=%b", gnt, 4'b0000); end
        tests++; if (sel !== 2'd0) begin fails++; $display("FAIL midrst_sel got=%0d exp=%0d", sel, 0); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=%b", out_valid, 1'b0); end
        rst_n = 1'b1;
        req   = 4'b0110;
        @(negedge clk);
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL midrst_regrant_gnt got=%b exp=%b", gnt, 4'b0010); end
        tests++; if (sel !== 2'd1) begin fails++; $display("FAIL midrst_regrant_sel got=%0d exp=%0d", sel, 1); end
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            @(negedge clk);
            tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL midrst_hold_gnt cyc=%0d got=%b exp=%b", i, gnt, 4'b0010); end
        end
        @(negedge clk);
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midrst_rotate_gnt got=%b exp=%b", gnt, 4'b0100); end
        $display("[TB] test_mid_reset: checks so far %0d", tests);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        in_data = '0;
        test_reset();
        test_single_owner();
        test_saturate();
        test_fair_rotation();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached after %0d checks", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
